// File: rtl/sobel_window_gen_if.sv
// sobel_window_gen_if: pixel stream in, 3x3 window stream out for the Sobel window generator.
interface sobel_window_gen_if #(
   parameter int PIXEL_WIDTH = 8,
   parameter int IMG_WIDTH   = 32,
   parameter int IMG_HEIGHT  = 32
);
   logic [PIXEL_WIDTH-1:0]        pixel_i;
   logic                          pixel_valid_i;
   logic                          sof_i;
   logic [9*PIXEL_WIDTH-1:0]      matrix_pixels_o;
   logic                          window_valid_o;
   logic [$clog2(IMG_WIDTH)-1:0]  center_col_o;
   logic [$clog2(IMG_HEIGHT)-1:0] center_row_o;
   logic                          frame_done_o;

   modport master (
      output pixel_i, pixel_valid_i, sof_i,
      input  matrix_pixels_o, window_valid_o, center_col_o, center_row_o, frame_done_o
   );
   modport slave (
      input  pixel_i, pixel_valid_i, sof_i,
      output matrix_pixels_o, window_valid_o, center_col_o, center_row_o, frame_done_o
   );
endinterface

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: two line buffers plus a 3x3 shift window, emitting one interior window per accepted pixel.
module sobel_window_gen #(
   parameter int PIXEL_WIDTH = 8,
   parameter int IMG_WIDTH   = 32,
   parameter int IMG_HEIGHT  = 32
) (
   input logic                 clk_i,
   input logic                 nreset_i,
   sobel_window_gen_if.slave   bus
);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);

   logic [1:0]                        rst_sync_q;
   logic                              rst_n;
   logic [CW-1:0]                     col_q, col_d, c;
   logic [RW-1:0]                     row_q, row_d, r;
   logic [PIXEL_WIDTH-1:0]            lb1_q [IMG_WIDTH];
   logic [PIXEL_WIDTH-1:0]            lb2_q [IMG_WIDTH];
   logic [0:2][0:2][PIXEL_WIDTH-1:0]  win_q, win_d;
   logic                              valid_q, valid_d, done_q, done_d;
   logic [CW-1:0]                     cc_q, cc_d;
   logic [RW-1:0]                     cr_q, cr_d;
   logic                              acc, last_col, last_row, interior;

   always_ff @(posedge clk_i or negedge nreset_i)
      if (!nreset_i) rst_sync_q <= 2'b00;
      else           rst_sync_q <= {rst_sync_q[0], 1'b1};
   assign rst_n = rst_sync_q[1];

   // sof_i forces the accepted pixel to (0,0), which also keeps stale rows out of windows
   assign acc      = bus.pixel_valid_i;
   assign c        = bus.sof_i ? '0 : col_q;
   assign r        = bus.sof_i ? '0 : row_q;
   assign last_col = c == CW'(IMG_WIDTH - 1);
   assign last_row = r == RW'(IMG_HEIGHT - 1);
   assign interior = c >= CW'(2) && r >= RW'(2);

   always_comb begin
      col_d   = acc ? (last_col ? '0 : c + 1'b1) : col_q;
      row_d   = acc ? (last_col ? (last_row ? '0 : r + 1'b1) : r) : row_q;
      win_d   = acc ? {win_q[0][1], win_q[0][2], lb2_q[c],
                       win_q[1][1], win_q[1][2], lb1_q[c],
                       win_q[2][1], win_q[2][2], bus.pixel_i} : win_q;
      valid_d = acc && interior;
      done_d  = acc && interior && last_col && last_row;
      cc_d    = (acc && interior) ? c - 1'b1 : cc_q;
      cr_d    = (acc && interior) ? r - 1'b1 : cr_q;
   end

   always_ff @(posedge clk_i)
      if (acc) begin
         lb2_q[c] <= lb1_q[c];
         lb1_q[c] <= bus.pixel_i;
      end

   always_ff @(posedge clk_i or negedge rst_n)
      if (!rst_n) begin
         col_q   <= '0;
         row_q   <= '0;
         win_q   <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         cc_q    <= '0;
         cr_q    <= '0;
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         win_q   <= win_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         cc_q    <= cc_d;
         cr_q    <= cr_d;
      end

   assign bus.matrix_pixels_o = win_q;
   assign bus.window_valid_o  = valid_q;
   assign bus.frame_done_o    = done_q;
   assign bus.center_col_o    = cc_q;
   assign bus.center_row_o    = cr_q;
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: table checkpoints on a ramp image plus a per-cycle image-array reference model.
module tb_sobel_window_gen;
   localparam int PW = 8;
   localparam int W  = 8;
   localparam int H  = 6;
   localparam int NWIN = (W - 2) * (H - 2);

   logic clk_i = 1'b0;
   logic nreset_i;
   always #5 clk_i = ~clk_i;

   sobel_window_gen_if #(.PIXEL_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();
   sobel_window_gen #(.PIXEL_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk_i(clk_i), .nreset_i(nreset_i), .bus(bus.slave)
   );

   int vectors = 0, miscompares = 0;
   int win_cnt = 0, done_cnt = 0;
   logic [PW-1:0] img [H][W];
   int mc = 0, mr = 0;
   logic exp_valid, exp_done;
   logic [9*PW-1:0] exp_mat;
   int exp_cc, exp_cr;

   typedef struct {
      int c; int r; logic v; logic d;
      int v00; int v11; int v22; int cc; int cr;
   } vec_t;
   vec_t tbl [7];

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic v, input logic s, input logic [PW-1:0] p);
      bus.pixel_valid_i = v;
      bus.sof_i         = s;
      bus.pixel_i       = p;
      @(posedge clk_i);
      exp_valid = 1'b0;
      exp_done  = 1'b0;
      if (v) begin
         if (s) begin mc = 0; mr = 0; end
         img[mr][mc] = p;
         if (mc >= 2 && mr >= 2) begin
            exp_valid = 1'b1;
            exp_done  = (mc == W - 1) && (mr == H - 1);
            exp_cc    = mc - 1;
            exp_cr    = mr - 1;
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  exp_mat[(8 - (3 * i + j)) * PW +: PW] = img[mr - 2 + i][mc - 2 + j];
         end
         mc++;
         if (mc == W) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
         end
      end
      #1;
      chk("valid", 72'(bus.window_valid_o), 72'(exp_valid));
      chk("done", 72'(bus.frame_done_o), 72'(exp_done));
      if (exp_valid) begin
         chk("matrix", 72'(bus.matrix_pixels_o), 72'(exp_mat));
         chk("center_col", 72'(bus.center_col_o), 72'(exp_cc));
         chk("center_row", 72'(bus.center_row_o), 72'(exp_cr));
      end
      if (bus.window_valid_o) win_cnt++;
      if (bus.frame_done_o) done_cnt++;
   endtask

   task automatic ramp_frame(input logic first_sof, input int from, input int to);
      for (int p = from; p < to; p++)
         step(1'b1, first_sof && p == 0, PW'(p % W + 16 * (p / W)));
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_matrix"}, 72'(bus.matrix_pixels_o), 72'(0));
      chk({name, "_valid"}, 72'(bus.window_valid_o), 72'(0));
      chk({name, "_done"}, 72'(bus.frame_done_o), 72'(0));
      chk({name, "_ccol"}, 72'(bus.center_col_o), 72'(0));
      chk({name, "_crow"}, 72'(bus.center_row_o), 72'(0));
   endtask

   initial begin
      int p;
      tbl[0] = '{1, 2, 1'b0, 1'b0, 0, 0, 0, 0, 0};
      tbl[1] = '{2, 2, 1'b1, 1'b0, 0, 17, 34, 1, 1};
      tbl[2] = '{0, 3, 1'b0, 1'b0, 0, 0, 0, 0, 0};
      tbl[3] = '{1, 3, 1'b0, 1'b0, 0, 0, 0, 0, 0};
      tbl[4] = '{2, 3, 1'b1, 1'b0, 16, 33, 50, 1, 2};
      tbl[5] = '{6, 5, 1'b1, 1'b0, 52, 69, 86, 5, 4};
      tbl[6] = '{7, 5, 1'b1, 1'b1, 53, 70, 87, 6, 4};

      nreset_i = 1'b0;
      bus.pixel_i = '0; bus.pixel_valid_i = 1'b0; bus.sof_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1 chk_zero("reset");
      nreset_i = 1'b1;
      repeat (3) step(1'b0, 1'b0, '0);

      // ramp frame with table checkpoints
      win_cnt = 0; done_cnt = 0; p = 0;
      for (int i = 0; i < 7; i++) begin
         while (p <= tbl[i].r * W + tbl[i].c) begin
            step(1'b1, p == 0, PW'(p % W + 16 * (p / W)));
            p++;
         end
         chk("tbl_valid", 72'(bus.window_valid_o), 72'(tbl[i].v));
         if (tbl[i].v) begin
            chk("tbl_v00", 72'(bus.matrix_pixels_o[71 -: 8]), 72'(tbl[i].v00));
            chk("tbl_v11", 72'(bus.matrix_pixels_o[39 -: 8]), 72'(tbl[i].v11));
            chk("tbl_v22", 72'(bus.matrix_pixels_o[7 -: 8]), 72'(tbl[i].v22));
            chk("tbl_ccol", 72'(bus.center_col_o), 72'(tbl[i].cc));
            chk("tbl_crow", 72'(bus.center_row_o), 72'(tbl[i].cr));
            chk("tbl_done", 72'(bus.frame_done_o), 72'(tbl[i].d));
         end
      end
      ramp_frame(1'b0, p, W * H);
      chk("frame1_count", 72'(win_cnt), 72'(NWIN));
      chk("frame1_done", 72'(done_cnt), 72'(1));

      // back-to-back frame, no sof
      win_cnt = 0; done_cnt = 0;
      ramp_frame(1'b0, 0, W * H);
      chk("frame2_count", 72'(win_cnt), 72'(NWIN));
      chk("frame2_done", 72'(done_cnt), 72'(1));

      // random pixels with ~50% valid gaps
      for (int f = 0; f < 2; f++) begin
         win_cnt = 0; done_cnt = 0; p = 0;
         while (p < W * H) begin
            logic v;
            v = 1'($urandom_range(0, 1));
            step(v, v && p == 0, PW'($urandom));
            if (v) p++;
         end
         step(1'b0, 1'b0, '0);
         chk("gap_count", 72'(win_cnt), 72'(NWIN));
         chk("gap_done", 72'(done_cnt), 72'(1));
      end

      // sof mid-frame at (4,3)
      ramp_frame(1'b1, 0, 3 * W + 4);
      win_cnt = 0; done_cnt = 0;
      ramp_frame(1'b1, 0, 2 * W + 2);
      chk("sof_no_early", 72'(win_cnt), 72'(0));
      ramp_frame(1'b0, 2 * W + 2, 2 * W + 3);
      chk("sof_first_valid", 72'(bus.window_valid_o), 72'(1));
      chk("sof_first_v00", 72'(bus.matrix_pixels_o[71 -: 8]), 72'(0));
      chk("sof_first_v22", 72'(bus.matrix_pixels_o[7 -: 8]), 72'(34));
      ramp_frame(1'b0, 2 * W + 3, W * H);
      chk("sof_count", 72'(win_cnt), 72'(NWIN));

      // async reset mid-frame at (5,4)
      ramp_frame(1'b1, 0, 4 * W + 5);
      #2 nreset_i = 1'b0;
      #1 chk_zero("midreset");
      mc = 0; mr = 0;
      repeat (2) step(1'b0, 1'b0, '0);
      nreset_i = 1'b1;
      repeat (3) step(1'b0, 1'b0, '0);
      win_cnt = 0; done_cnt = 0;
      ramp_frame(1'b0, 0, W * H);
      chk("postreset_count", 72'(win_cnt), 72'(NWIN));
      chk("postreset_done", 72'(done_cnt), 72'(1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
